l1_port_arbiter: RTL and testbench

Shares one port of the dual-port L1 data memory between two requesters, e.g. core load/store unit (req 0) and a DMA/bus bridge (req 1). Per-cycle round-robin arbitration with an optional lock for atomic sequences and bursts. A bounded lock length prevents starvation. Read data is routed back with a registered valid, aligned to the memory's one-cycle read latency.

---
 rtl/l1_port_arbiter_pkg.sv | 19 +
 rtl/l1_port_arbiter_if.sv | 30 +++
 rtl/l1_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_l1_port_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/l1_port_arbiter_pkg.sv
// Shared types and helpers for the L1 data-memory port arbiter.
package l1_arb_pkg;

  // Ownership state: free arbitration or locked to one requester.
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  // Requester index (0 = load/store unit, 1 = DMA/bus bridge).
  typedef logic req_id_t;

  // Number of byte lanes needed to cover a data word.
  function automatic int byte_count(input int data_width);
    return (data_width + 32'sd7) / 32'sd8;
  endfunction

endpackage

// File: rtl/l1_port_arbiter_if.sv
// Requester-side bundle of the L1 port arbiter: two request channels plus
// shared read-return signals.
interface l1_port_arbiter_if
  import l1_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  localparam int BYTE_COUNT = byte_count(DATA_WIDTH);

  logic [1:0]                       req_i;
  logic [1:0]                       lock_i;
  logic [1:0]                       we_i;
  logic [1:0][BYTE_COUNT-1:0]       be_i;
  logic [1:0][ADDR_WIDTH-1:0]       addr_i;
  logic [1:0][DATA_WIDTH-1:0]       wdata_i;
  logic [1:0]                       gnt_o;
  logic [1:0]                       rvalid_o;
  logic [DATA_WIDTH-1:0]            rdata_o;

  modport master (
    output req_i, lock_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, lock_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/l1_port_arbiter.sv
// Two-requester arbiter for one port of the L1 data memory. Round-robin per
// cycle, optional bounded lock for atomic sequences/bursts, and routing of
// one-cycle-latency read data back to the requester that issued the read.
module l1_port_arbiter
  import l1_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  l1_port_arbiter_if.slave      bus,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [byte_count(DATA_WIDTH)-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_delay
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  arb_state_t       state_r, state_n_s;
  req_id_t          last_gnt_r;
  logic [CNT_W-1:0] lock_cnt_r, lock_cnt_n_s;
  logic             rd_pend_r;
  req_id_t          rd_owner_r;

  req_id_t          sel_s;
  req_id_t          owner_s;
  logic             in_lock_s;
  logic             abandon_s;
  logic             force_s;
  logic             acc_s;

  // Selection of the requester driving the memory port this cycle.
  always_comb begin
    owner_s   = (state_r == LOCK1) ? 1'b1 : 1'b0;
    in_lock_s = (state_r != ARB);
    abandon_s = in_lock_s & ~bus.req_i[owner_s];
    force_s   = in_lock_s & (lock_cnt_r == MAX_CNT) & bus.req_i[~owner_s];
    sel_s     = 1'b0;
    if (in_lock_s) begin
      // A forced release hands the port to the waiting side immediately.
      if (force_s) begin
        sel_s = ~owner_s;
      end else begin
        sel_s = owner_s;
      end
    end else if (bus.req_i == 2'b01) begin
      sel_s = 1'b0;
    end else if (bus.req_i == 2'b10) begin
      sel_s = 1'b1;
    end else begin
      sel_s = ~last_gnt_r;
    end
  end

  // Memory port drive and grant; gated by reset so nothing leaks out during it.
  always_comb begin
    mem_en    = bus.req_i[sel_s] & reset;
    mem_we    = bus.we_i[sel_s];
    mem_be    = bus.be_i[sel_s];
    mem_addr  = bus.addr_i[sel_s];
    mem_wdata = bus.wdata_i[sel_s];
    acc_s     = mem_en & ~mem_delay;
    if (acc_s) begin
      bus.gnt_o = sel_s ? 2'b10 : 2'b01;
    end else begin
      bus.gnt_o = 2'b00;
    end
    bus.rvalid_o = rd_pend_r ? (rd_owner_r ? 2'b10 : 2'b01) : 2'b00;
    bus.rdata_o  = mem_rdata;
  end

  // Lock FSM next-state and lock-length counter.
  always_comb begin
    state_n_s    = state_r;
    lock_cnt_n_s = lock_cnt_r;
    case (state_r)
      ARB: begin
        if (acc_s && bus.lock_i[sel_s]) begin
          state_n_s    = sel_s ? LOCK1 : LOCK0;
          lock_cnt_n_s = ONE_CNT;
        end else begin
          state_n_s    = ARB;
        end
      end
      LOCK0, LOCK1: begin
        if (force_s) begin
          // The forced winner may itself start a lock on this access.
          if (acc_s && bus.lock_i[sel_s]) begin
            state_n_s    = sel_s ? LOCK1 : LOCK0;
            lock_cnt_n_s = ONE_CNT;
          end else if (acc_s) begin
            state_n_s    = ARB;
            lock_cnt_n_s = '0;
          end else begin
            state_n_s    = state_r;
          end
        end else if (abandon_s) begin
          state_n_s    = ARB;
          lock_cnt_n_s = '0;
        end else if (acc_s && bus.lock_i[owner_s]) begin
          lock_cnt_n_s = (lock_cnt_r == MAX_CNT) ? MAX_CNT : lock_cnt_r + ONE_CNT;
        end else if (acc_s) begin
          state_n_s    = ARB;
          lock_cnt_n_s = '0;
        end else begin
          state_n_s    = state_r;
        end
      end
      default: begin
        state_n_s    = ARB;
        lock_cnt_n_s = '0;
      end
    endcase
  end

  // FSM, round-robin pointer and read-return tracking registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ARB;
      last_gnt_r <= 1'b1;
      lock_cnt_r <= '0;
      rd_pend_r  <= 1'b0;
      rd_owner_r <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      lock_cnt_r <= lock_cnt_n_s;
      if (acc_s) begin
        last_gnt_r <= sel_s;
        rd_pend_r  <= ~bus.we_i[sel_s];
        rd_owner_r <= sel_s;
      end else begin
        rd_pend_r  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_l1_port_arbiter.sv
// Directed self-checking bench for l1_port_arbiter with a byte-enabled
// one-cycle-latency memory model.
module tb_l1_port_arbiter;
  import l1_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_en, mem_we, mem_delay;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] mem [0:1023];
  logic [31:0] merged;
  int tests_run = 0;
  int tests_failed = 0;

  l1_port_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

  l1_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_LOCK(8)) dut (
    .clk(clk), .reset(rst_n), .bus(bus),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_delay(mem_delay)
  );

  always #5 clk = ~clk;

  // Synchronous memory: byte-enabled write, registered read.
  always @(posedge clk) begin
    if (mem_en && !mem_delay) begin
      if (mem_we) begin
        merged = mem[mem_addr];
        for (int b = 0; b < 4; b++) if (mem_be[b]) merged[8*b +: 8] = mem_wdata[8*b +: 8];
        mem[mem_addr] <= merged;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic idle();
    bus.req_i = 2'b00; bus.lock_i = 2'b00; bus.we_i = 2'b00; mem_delay = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.req_i = 2'b11; #2;
    tests_run++; if (bus.gnt_o !== 2'b00) begin tests_failed++; $display("FAIL reset_gnt: got %b want 00", bus.gnt_o); end
    tests_run++; if (mem_en !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
    tests_run++; if (bus.rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL reset_rvalid: got %b want 00", bus.rvalid_o); end
    @(posedge clk); #1;
    bus.req_i = 2'b00; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    bus.addr_i[0] = 10'h010; bus.addr_i[1] = 10'h020; bus.we_i = 2'b00; bus.lock_i = 2'b00;
    bus.req_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      #2;
      tests_run++; if (bus.gnt_o !== exp) begin tests_failed++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, bus.gnt_o, exp); end
      @(posedge clk); #1;
      tests_run++; if (bus.rvalid_o !== exp) begin tests_failed++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, bus.rvalid_o, exp); end
      tests_run++;
      if (bus.rdata_o !== ((exp == 2'b01) ? 32'hA5A50010 : 32'hA5A50020)) begin
        tests_failed++; $display("FAIL rr_rdata[%0d]: got %h", i, bus.rdata_o);
      end
    end
    idle();
  endtask

  task automatic test_lock_burst();
    bus.addr_i[0] = 10'h100; bus.wdata_i[0] = 32'h11110000; bus.be_i[0] = 4'hF;
    bus.addr_i[1] = 10'h020; bus.we_i = 2'b01; bus.req_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      bus.lock_i = (i < 3) ? 2'b01 : 2'b00;
      #2;
      tests_run++; if (bus.gnt_o !== 2'b01) begin tests_failed++; $display("FAIL burst_gnt[%0d]: got %b want 01", i, bus.gnt_o); end
      @(posedge clk); #1;
      tests_run++; if (bus.rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL burst_rvalid[%0d]: got %b want 00", i, bus.rvalid_o); end
    end
    bus.lock_i = 2'b00; #2;
    tests_run++; if (bus.gnt_o !== 2'b10) begin tests_failed++; $display("FAIL burst_handover: got %b want 10", bus.gnt_o); end
    @(posedge clk); #1;
    tests_run++; if (bus.rvalid_o !== 2'b10) begin tests_failed++; $display("FAIL burst_rvalid1: got %b want 10", bus.rvalid_o); end
    tests_run++; if (bus.rdata_o !== 32'hA5A50020) begin tests_failed++; $display("FAIL burst_rdata1: got %h want a5a50020", bus.rdata_o); end
    bus.we_i = 2'b00; bus.addr_i[0] = 10'h010; #2;
    tests_run++; if (bus.gnt_o !== 2'b01) begin tests_failed++; $display("FAIL burst_rr_resume: got %b want 01", bus.gnt_o); end
    @(posedge clk); #1;
    tests_run++; if (bus.rdata_o !== 32'hA5A50010) begin tests_failed++; $display("FAIL burst_rdata0: got %h want a5a50010", bus.rdata_o); end
    idle();
  endtask

  task automatic test_forced_release();
    logic [1:0] exp;
    bus.addr_i[0] = 10'h200; bus.wdata_i[0] = 32'h22220000; bus.be_i[0] = 4'hF;
    bus.addr_i[1] = 10'h020; bus.we_i = 2'b01; bus.lock_i = 2'b01;
    for (int i = 0; i < 10; i++) begin
      bus.req_i = (i == 0) ? 2'b01 : 2'b11;
      exp = (i == 8) ? 2'b10 : 2'b01;
      #2;
      tests_run++; if (bus.gnt_o !== exp) begin tests_failed++; $display("FAIL force_gnt[%0d]: got %b want %b", i, bus.gnt_o, exp); end
      @(posedge clk); #1;
      tests_run++;
      if (bus.rvalid_o !== ((i == 8) ? 2'b10 : 2'b00)) begin
        tests_failed++; $display("FAIL force_rvalid[%0d]: got %b", i, bus.rvalid_o);
      end
    end
    bus.req_i = 2'b00; #2;
    tests_run++; if (bus.gnt_o !== 2'b00) begin tests_failed++; $display("FAIL abandon_gnt: got %b want 00", bus.gnt_o); end
    @(posedge clk); #1;
    bus.req_i = 2'b11; bus.lock_i = 2'b00; #2;
    tests_run++; if (bus.gnt_o !== 2'b10) begin tests_failed++; $display("FAIL after_abandon_gnt: got %b want 10", bus.gnt_o); end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_mem_delay();
    bus.addr_i[1] = 10'h020; bus.we_i = 2'b00; bus.lock_i = 2'b00; bus.req_i = 2'b10; mem_delay = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      tests_run++; if (bus.gnt_o !== 2'b00) begin tests_failed++; $display("FAIL delay_gnt[%0d]: got %b want 00", i, bus.gnt_o); end
      tests_run++; if (mem_addr !== 10'h020 || mem_en !== 1'b1) begin tests_failed++; $display("FAIL delay_port[%0d]: addr %h en %b want 020 1", i, mem_addr, mem_en); end
      @(posedge clk); #1;
      tests_run++; if (bus.rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL delay_rvalid[%0d]: got %b want 00", i, bus.rvalid_o); end
    end
    mem_delay = 1'b0; #2;
    tests_run++; if (bus.gnt_o !== 2'b10) begin tests_failed++; $display("FAIL delay_release_gnt: got %b want 10", bus.gnt_o); end
    @(posedge clk); #1;
    tests_run++; if (bus.rvalid_o !== 2'b10) begin tests_failed++; $display("FAIL delay_rvalid: got %b want 10", bus.rvalid_o); end
    tests_run++; if (bus.rdata_o !== 32'hA5A50020) begin tests_failed++; $display("FAIL delay_rdata: got %h want a5a50020", bus.rdata_o); end
    idle();
  endtask

  task automatic test_reset_mid_read();
    bus.addr_i[0] = 10'h010; bus.addr_i[1] = 10'h020; bus.we_i = 2'b00; bus.req_i = 2'b01; #2;
    tests_run++; if (bus.gnt_o !== 2'b01) begin tests_failed++; $display("FAIL midrst_gnt: got %b want 01", bus.gnt_o); end
    @(posedge clk);
    rst_n = 1'b0; bus.req_i = 2'b11; #1;
    tests_run++; if (bus.rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL midrst_rvalid: got %b want 00", bus.rvalid_o); end
    tests_run++; if (bus.gnt_o !== 2'b00 || mem_en !== 1'b0) begin tests_failed++; $display("FAIL midrst_quiet: gnt %b en %b want 00 0", bus.gnt_o, mem_en); end
    @(posedge clk); #1;
    tests_run++; if (bus.rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL midrst_no_replay: got %b want 00", bus.rvalid_o); end
    rst_n = 1'b1; #2;
    tests_run++; if (bus.gnt_o !== 2'b01) begin tests_failed++; $display("FAIL midrst_first_tie: got %b want 01", bus.gnt_o); end
    @(posedge clk); #1;
    tests_run++; if (bus.rvalid_o !== 2'b01) begin tests_failed++; $display("FAIL midrst_rvalid_after: got %b want 01", bus.rvalid_o); end
    idle();
  endtask

  task automatic test_byte_enable();
    bus.addr_i[1] = 10'h3FF; bus.wdata_i[1] = 32'hDEADBEEF; bus.be_i[1] = 4'b0011;
    bus.we_i = 2'b10; bus.req_i = 2'b10; #2;
    tests_run++; if (bus.gnt_o !== 2'b10) begin tests_failed++; $display("FAIL be_wr_gnt: got %b want 10", bus.gnt_o); end
    tests_run++;
    if (mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 10'h3FF) begin
      tests_failed++; $display("FAIL be_wr_port: we %b be %b wdata %h addr %h", mem_we, mem_be, mem_wdata, mem_addr);
    end
    @(posedge clk); #1;
    tests_run++; if (bus.rvalid_o !== 2'b00) begin tests_failed++; $display("FAIL be_wr_rvalid: got %b want 00", bus.rvalid_o); end
    bus.addr_i[0] = 10'h3FF; bus.we_i = 2'b00; bus.req_i = 2'b01; #2;
    tests_run++; if (bus.gnt_o !== 2'b01) begin tests_failed++; $display("FAIL be_rd_gnt: got %b want 01", bus.gnt_o); end
    @(posedge clk); #1;
    tests_run++; if (bus.rvalid_o !== 2'b01) begin tests_failed++; $display("FAIL be_rd_rvalid: got %b want 01", bus.rvalid_o); end
    tests_run++; if (bus.rdata_o !== 32'h1234BEEF) begin tests_failed++; $display("FAIL be_rd_rdata: got %h want 1234beef", bus.rdata_o); end
    idle();
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 32'h0;
    mem[10'h010] = 32'hA5A50010;
    mem[10'h020] = 32'hA5A50020;
    mem[10'h3FF] = 32'h12345678;
    rst_n = 1'b0; mem_delay = 1'b0;
    bus.req_i = 2'b00; bus.lock_i = 2'b00; bus.we_i = 2'b00;
    bus.be_i = '0; bus.addr_i = '0; bus.wdata_i = '0;
    @(posedge clk); #1;
    test_reset();
    test_round_robin();
    test_lock_burst();
    test_forced_release();
    test_mem_delay();
    test_reset_mid_read();
    test_byte_enable();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
